// File: rtl/freq_sel_ctrl.sv
// freq_sel_ctrl: frequency index sequencer and half-period divider.
// Holds the frequency index sent to the divider-count translator.
// Divides clk by the returned count into a square wave.
// Index changes are applied only at half-period boundaries.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   en         run enable; low freezes the divider
//   btn_up     one-cycle request for the next higher index
//   btn_dn     one-cycle request for the next lower index
//   auto_sweep automatic index sweep enable
//              (present only with FREQ_SEL_AUTO_SWEEP_EN)
//   div_in     half-period count from the translator
//   sel_out    current index to the translator
//   wave_out   divided square wave
//   tick       one-cycle pulse after every wave_out toggle
//   busy       waiting for the translator after an index change
//   err        translator returned an illegal count of zero
//
// Build option: define FREQ_SEL_AUTO_SWEEP_EN to add the sweep.
module freq_sel_ctrl #(
    parameter int SEL_W      = 3,
    parameter int CNT_W      = 7,
    parameter int SEL_MAX    = 7,
    parameter int XLAT_LAT   = 1,
    parameter int SWEEP_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             btn_up,
    input  logic             btn_dn,
`ifdef FREQ_SEL_AUTO_SWEEP_EN
    input  logic             auto_sweep,
`endif
    input  logic [CNT_W-1:0] div_in,
    output logic [SEL_W-1:0] sel_out,
    output logic             wave_out,
    output logic             tick,
    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam int WAIT_W = $clog2(XLAT_LAT + 2);
    localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(XLAT_LAT);
    localparam logic [SEL_W-1:0] MAX_IDX = SEL_W'(SEL_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state;
    logic [WAIT_W-1:0] wcnt;
    logic [CNT_W-1:0]  cnt;
    logic [SEL_W-1:0]  pend_idx;
    logic              pend;

    logic              req_up;
    logic              req_dn;
    logic              req;
    logic [SEL_W-1:0]  req_idx;
    logic              boundary;
    logic              gate_btn;

`ifdef FREQ_SEL_AUTO_SWEEP_EN
    localparam int SWEEP_TOP = 2 * SWEEP_HOLD;
    localparam int SW_W = $clog2(SWEEP_TOP + 1);
    localparam logic [SW_W-1:0] SW_LAST = SW_W'(SWEEP_TOP - 1);

    logic [SW_W-1:0]  sweep_cnt;
    logic             sweep_fire;
    logic [SEL_W-1:0] sweep_idx;

    // Buttons are locked out while the sweep owns the index.
    assign gate_btn = auto_sweep;
`else
    assign gate_btn = 1'b0;
`endif

    // Pressing both buttons in one cycle is treated as no request.
    assign req_up = btn_up & ~btn_dn & ~gate_btn;
    assign req_dn = btn_dn & ~btn_up & ~gate_btn;
    assign req    = req_up | req_dn;

    assign boundary = (state == RUN) && en && (cnt == '0);

    // Requests accumulate onto the pending index, saturating.
    always_comb begin
        req_idx = pend_idx;
        if (req_up && (pend_idx < MAX_IDX)) begin
            req_idx = pend_idx + SEL_W'(1);
        end else if (req_dn && (pend_idx != '0)) begin
            req_idx = pend_idx - SEL_W'(1);
        end
    end

`ifdef FREQ_SEL_AUTO_SWEEP_EN
    always_comb begin
        sweep_fire = auto_sweep && boundary && (sweep_cnt == SW_LAST);
        sweep_idx  = (sel_out == MAX_IDX) ? '0 : sel_out + SEL_W'(1);
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= WAIT;
            wcnt     <= '0;
            cnt      <= '0;
            sel_out  <= '0;
            pend_idx <= '0;
            pend     <= 1'b0;
            wave_out <= 1'b0;
            tick     <= 1'b0;
            busy     <= 1'b1;
            err      <= 1'b0;
`ifdef FREQ_SEL_AUTO_SWEEP_EN
            sweep_cnt <= '0;
`endif
        end else begin
            tick <= 1'b0;

            unique case (state)
                WAIT: begin
                    busy <= 1'b1;
                    if (wcnt == WAIT_TOP) begin
                        // Translator output now reflects sel_out.
                        wcnt <= '0;
                        busy <= 1'b0;
                        if (div_in == '0) begin
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            cnt   <= div_in - CNT_ONE;
                            err   <= 1'b0;
                            state <= RUN;
                        end
                    end else begin
                        wcnt <= wcnt + WAIT_W'(1);
                    end
                end

                RUN: begin
                    if (!en) begin
                        // Frozen: a pending change may go now,
                        // since there is no edge to protect.
                        if (pend) begin
                            pend <= 1'b0;
                            if (pend_idx != sel_out) begin
                                sel_out <= pend_idx;
                                busy    <= 1'b1;
                                state   <= WAIT;
                            end
                        end
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        wave_out <= ~wave_out;
                        tick     <= 1'b1;
                        pend     <= 1'b0;
                        if (pend && (pend_idx != sel_out)) begin
                            sel_out <= pend_idx;
                            busy    <= 1'b1;
                            state   <= WAIT;
                        end else if (div_in == '0) begin
                            // Reloading zero would wrap; park.
                            err   <= 1'b1;
                            state <= HALT;
                        end else begin
                            cnt <= div_in - CNT_ONE;
                        end
                    end
                end

                HALT: begin
                    busy <= 1'b0;
                    err  <= 1'b1;
                    if (req) begin
                        sel_out <= req_idx;
                        pend    <= 1'b0;
                        busy    <= 1'b1;
                        state   <= WAIT;
                    end
                end

                default: begin
                    state <= WAIT;
                    wcnt  <= '0;
                    busy  <= 1'b1;
                end
            endcase

            // A request always survives the boundary it lands on,
            // so it is merged after the state update.
            if (req) begin
                pend_idx <= req_idx;
                if (state != HALT) begin
                    pend <= 1'b1;
                end
            end

`ifdef FREQ_SEL_AUTO_SWEEP_EN
            if (!auto_sweep) begin
                sweep_cnt <= '0;
            end else if (boundary) begin
                sweep_cnt <= sweep_fire ? '0 : sweep_cnt + SW_W'(1);
            end
            if (sweep_fire) begin
                pend_idx <= sweep_idx;
                pend     <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_freq_sel_ctrl.sv
// tb_freq_sel_ctrl: directed bench for freq_sel_ctrl.
// Models a one-cycle-latency translator and checks tick spacing.
module tb_freq_sel_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic       btn_up;
    logic       btn_dn;
    logic [6:0] div_in;
    logic [2:0] sel_out;
    logic       wave_out;
    logic       tick;
    logic       busy;
    logic       err;
`ifdef FREQ_SEL_AUTO_SWEEP_EN
    logic       auto_sweep;
`endif

    logic force0;
    logic exp_wave;
    int   n_pass;
    int   n_total;
    int   n;

    freq_sel_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_up   (btn_up),
        .btn_dn   (btn_dn),
`ifdef FREQ_SEL_AUTO_SWEEP_EN
        .auto_sweep (auto_sweep),
`endif
        .div_in   (div_in),
        .sel_out  (sel_out),
        .wave_out (wave_out),
        .tick     (tick),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] lut(input logic [2:0] s);
        case (s)
            3'd0: lut = 7'd104;
            3'd1: lut = 7'd62;
            3'd2: lut = 7'd41;
            3'd3: lut = 7'd31;
            3'd4: lut = 7'd20;
            3'd5: lut = 7'd12;
            3'd6: lut = 7'd8;
            default: lut = 7'd5;
        endcase
    endfunction

    // Translator: registered, one cycle of latency.
    always @(posedge clk) div_in <= force0 ? 7'd0 : lut(sel_out);

    task automatic chk(input string tag, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Steps until tick, returning the number of edges taken.
    task automatic wait_tick(output int cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (!tick && cyc < 300);
        if (!tick) begin
            chk("tick_timeout", 0, 1);
        end else begin
            exp_wave = ~exp_wave;
            chk("wave_lvl", int'(wave_out), int'(exp_wave));
        end
    endtask

    task automatic pulse(input logic up, input logic dn);
        btn_up = up;
        btn_dn = dn;
        step(1);
        btn_up = 1'b0;
        btn_dn = 1'b0;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        exp_wave = 1'b0;
        force0   = 1'b0;
        rst      = 1'b0;
        en       = 1'b1;
        btn_up   = 1'b0;
        btn_dn   = 1'b0;
        div_in   = 7'd0;
`ifdef FREQ_SEL_AUTO_SWEEP_EN
        auto_sweep = 1'b0;
`endif
        step(3);
        chk("rst_sel", int'(sel_out), 0);
        chk("rst_wave", int'(wave_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_err", int'(err), 0);

        // Start-up: busy for two edges, first tick 104 later.
        rst = 1'b1;
        step(1);
        chk("wait_busy1", int'(busy), 1);
        step(1);
        chk("wait_busy2", int'(busy), 0);
        wait_tick(n);
        chk("first_half", n, 104);
        wait_tick(n);
        chk("half_104", n, 104);
        chk("sel_0", int'(sel_out), 0);

        // Down at index 0 saturates: no WAIT, same period.
        step(10);
        pulse(1'b0, 1'b1);
        wait_tick(n);
        chk("dn_sat_len", n, 93);
        chk("dn_sat_sel", int'(sel_out), 0);
        chk("dn_sat_busy", int'(busy), 0);
        wait_tick(n);
        chk("dn_sat_next", n, 104);

        // Both buttons at once are ignored.
        step(10);
        pulse(1'b1, 1'b1);
        wait_tick(n);
        chk("both_len", n, 93);
        chk("both_sel", int'(sel_out), 0);
        chk("both_busy", int'(busy), 0);
        wait_tick(n);
        chk("both_next", n, 104);

        // Zero count: park in HALT, wave frozen.
        force0 = 1'b1;
        wait_tick(n);
        chk("zero_len", n, 104);
        chk("zero_err", int'(err), 1);
        chk("zero_busy", int'(busy), 0);
        step(10);
        chk("halt_wave", int'(wave_out), int'(exp_wave));
        chk("halt_tick", int'(tick), 0);
        chk("halt_err", int'(err), 1);
        force0 = 1'b0;
        step(1);
        pulse(1'b1, 1'b0);
        chk("halt_sel", int'(sel_out), 1);
        chk("halt_busy", int'(busy), 1);
        step(2);
        chk("recov_err", int'(err), 0);
        chk("recov_busy", int'(busy), 0);
        wait_tick(n);
        chk("half_62", n, 62);

        // Two ups mid-period: index 1 -> 3 at the boundary.
        step(10);
        pulse(1'b1, 1'b0);
        step(1);
        pulse(1'b1, 1'b0);
        step(1);
        chk("hold_sel", int'(sel_out), 1);
        wait_tick(n);
        chk("up_len", n, 48);
        chk("up_sel", int'(sel_out), 3);
        chk("up_busy", int'(busy), 1);
        step(2);
        chk("up_busy2", int'(busy), 0);
        wait_tick(n);
        chk("half_31a", n, 31);
        wait_tick(n);
        chk("half_31b", n, 31);

        // Four more ups: 3 -> 7.
        step(5);
        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b0);
            step(1);
        end
        wait_tick(n);
        chk("to7_len", n, 18);
        chk("to7_sel", int'(sel_out), 7);
        step(2);
        wait_tick(n);
        chk("half_5", n, 5);

        // Up at index 7 saturates.
        pulse(1'b1, 1'b0);
        wait_tick(n);
        chk("up_sat_len", n, 4);
        chk("up_sat_sel", int'(sel_out), 7);
        chk("up_sat_busy", int'(busy), 0);
        wait_tick(n);
        chk("up_sat_next", n, 5);

        // Request on the boundary edge waits one half-period.
        step(4);
        pulse(1'b0, 1'b1);
        chk("bnd_tick", int'(tick), 1);
        exp_wave = ~exp_wave;
        chk("bnd_sel", int'(sel_out), 7);
        chk("bnd_busy", int'(busy), 0);
        wait_tick(n);
        chk("bnd_len", n, 5);
        chk("bnd_sel2", int'(sel_out), 6);
        chk("bnd_busy2", int'(busy), 1);

        // en low freezes the count.
        step(2);
        step(3);
        en = 1'b0;
        step(5);
        chk("frz_tick", int'(tick), 0);
        chk("frz_wave", int'(wave_out), int'(exp_wave));
        chk("frz_busy", int'(busy), 0);
        en = 1'b1;
        wait_tick(n);
        chk("frz_len", n, 5);

        // Async reset with a change pending and en low.
        step(2);
        pulse(1'b1, 1'b0);
        en = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_sel", int'(sel_out), 0);
        chk("arst_wave", int'(wave_out), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_busy", int'(busy), 1);
        chk("arst_err", int'(err), 0);
        step(2);
        rst      = 1'b1;
        en       = 1'b1;
        exp_wave = 1'b0;
        step(2);
        chk("rest_busy", int'(busy), 0);
        chk("rest_sel", int'(sel_out), 0);
        wait_tick(n);
        chk("rest_len", n, 104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
